// File: rtl/branch_predictor_if.sv
// Fetch/EX bundle for the branch predictor: lookup side,
// resolution update side and the statistics counters.
interface branch_predictor_if #(
  parameter int IDX_W = 4
) ();
  logic [31:0]      lookup_pc;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;

  logic             update_en;
  logic [IDX_W-1:0] update_idx;
  logic [31:0]      update_pc;
  logic             update_taken;
  logic [31:0]      update_target;
  logic             update_mispredict;

  logic [31:0]      branch_cnt;
  logic [31:0]      mispred_cnt;

  modport master (
    output lookup_pc,
    output update_en, update_idx, update_pc,
    output update_taken, update_target,
    output update_mispredict,
    input  pred_idx, pred_hit, pred_taken,
    input  pred_target,
    input  branch_cnt, mispred_cnt
  );

  modport slave (
    input  lookup_pc,
    input  update_en, update_idx, update_pc,
    input  update_taken, update_target,
    input  update_mispredict,
    output pred_idx, pred_hit, pred_taken,
    output pred_target,
    output branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// BTB with per-entry saturating direction counters,
// optional gshare indexing and branch/mispredict statistics.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8,
  parameter int GHR_BITS = 0
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;

  localparam logic [CTR_BITS-1:0] CTR_WNT =
    CTR_BITS'((1 << (CTR_BITS-1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT =
    CTR_BITS'(1 << (CTR_BITS-1));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [31:0]         tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
  logic [GW-1:0]       ghr_q;

  logic [31:0]         brn_q;
  logic [31:0]         mis_q;

  logic [IDX_W+GW-1:0] ghr_ext;
  logic [GW:0]         ghr_nxt;
  logic [IDX_W-1:0]    base;
  logic [IDX_W-1:0]    idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [TAG_BITS-1:0] u_tag;
  logic                lk_hit;
  logic                u_hit;
  logic                u_alloc;

  // history is zero-extended then truncated to the index width
  assign ghr_ext = {{IDX_W{1'b0}}, ghr_q};
  assign ghr_nxt = {ghr_q, bus.update_taken};

  assign base   = bus.lookup_pc[IDX_W+1:2];
  assign idx    = (GHR_BITS > 0) ?
                  (base ^ ghr_ext[IDX_W-1:0]) : base;
  assign lk_tag = bus.lookup_pc[IDX_W+2 +: TAG_BITS];
  assign lk_hit = valid_q[idx] && (tag_q[idx] == lk_tag);

  assign bus.pred_idx    = idx;
  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_hit && ctr_q[idx][CTR_BITS-1];
  assign bus.pred_target = bus.pred_taken ? tgt_q[idx]
                         : bus.lookup_pc + 32'd4;

  assign u_tag   = bus.update_pc[IDX_W+2 +: TAG_BITS];
  assign u_hit   = valid_q[bus.update_idx] &&
                   (tag_q[bus.update_idx] == u_tag);
  assign u_alloc = !u_hit && bus.update_taken;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
      ghr_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++)
        valid_q[i] <= 1'b0;
      ghr_q <= '0;
    end else if (bus.update_en) begin
      unique case (1'b1)
        u_hit: begin
          if (bus.update_taken) begin
            if (ctr_q[bus.update_idx] != CTR_MAX)
              ctr_q[bus.update_idx] <=
                ctr_q[bus.update_idx] + 1'b1;
            tgt_q[bus.update_idx] <= bus.update_target;
          end else if (ctr_q[bus.update_idx] != '0) begin
            ctr_q[bus.update_idx] <=
              ctr_q[bus.update_idx] - 1'b1;
          end
        end
        u_alloc: begin
          valid_q[bus.update_idx] <= 1'b1;
          tag_q[bus.update_idx]   <= u_tag;
          tgt_q[bus.update_idx]   <= bus.update_target;
          ctr_q[bus.update_idx]   <= CTR_WT;
        end
        default: ;
      endcase
      if (GHR_BITS > 0)
        ghr_q <= ghr_nxt[GW-1:0];
    end
  end

  // statistics keep counting through clear
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      brn_q <= '0;
      mis_q <= '0;
    end else if (bus.update_en) begin
      if (brn_q != 32'hFFFF_FFFF)
        brn_q <= brn_q + 32'd1;
      if (bus.update_mispredict &&
          mis_q != 32'hFFFF_FFFF)
        mis_q <= mis_q + 32'd1;
    end
  end

  assign bus.branch_cnt  = brn_q;
  assign bus.mispred_cnt = mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of a bimodal and a gshare
// branch predictor against a table model kept in the bench.
module tb_branch_predictor;
  logic CLK;
  logic nRST;
  logic clear;

  int checks   = 0;
  int failures = 0;

  branch_predictor_if #(.IDX_W(4)) bus0 ();
  branch_predictor_if #(.IDX_W(4)) bus1 ();

  branch_predictor u0 (
    .CLK(CLK), .nRST(nRST), .clear(clear), .bus(bus0)
  );

  branch_predictor #(.GHR_BITS(4)) u1 (
    .CLK(CLK), .nRST(nRST), .clear(clear), .bus(bus1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // model: one table per instance, 0 = bimodal, 1 = gshare
  int mv   [2][16];
  int mtag [2][16];
  int mtgt [2][16];
  int mctr [2][16];
  int mghr [2];
  int mbr;
  int mmis;

  function automatic int m_idx(int m, logic [31:0] pc);
    int b;
    b = int'((pc >> 2) % 16);
    if (m == 1) b = b ^ (mghr[1] % 16);
    return b;
  endfunction

  function automatic int m_tag(logic [31:0] pc);
    return int'((pc >> 6) % 256);
  endfunction

  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        mv[m][i] = 0; mtag[m][i] = 0;
        mtgt[m][i] = 0; mctr[m][i] = 1;
      end
      mghr[m] = 0;
    end
    mbr = 0; mmis = 0;
  endtask

  task automatic m_clear();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) mv[m][i] = 0;
      mghr[m] = 0;
    end
  endtask

  task automatic m_apply(int m, int i, logic [31:0] pc,
                         bit tk, logic [31:0] tg);
    if (mv[m][i] == 1 && mtag[m][i] == m_tag(pc)) begin
      if (tk) begin
        mctr[m][i] = (mctr[m][i] + 1 > 3) ? 3 : mctr[m][i] + 1;
        mtgt[m][i] = int'(tg);
      end else begin
        mctr[m][i] = (mctr[m][i] - 1 < 0) ? 0 : mctr[m][i] - 1;
      end
    end else if (tk) begin
      mv[m][i] = 1; mtag[m][i] = m_tag(pc);
      mtgt[m][i] = int'(tg); mctr[m][i] = 2;
    end
    if (m == 1) mghr[1] = ((mghr[1] << 1) | int'(tk)) % 16;
  endtask

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // drive a lookup on both instances and compare against the model
  task automatic look(logic [31:0] pc);
    int i, h, t;
    logic [31:0] tg;
    logic [3:0] o_idx;
    logic o_hit, o_tk;
    logic [31:0] o_tg, o_bc, o_mc;
    bus0.lookup_pc = pc;
    bus1.lookup_pc = pc;
    #1;
    for (int m = 0; m < 2; m++) begin
      i  = m_idx(m, pc);
      h  = (mv[m][i] == 1 && mtag[m][i] == m_tag(pc)) ? 1 : 0;
      t  = (h == 1 && mctr[m][i] >= 2) ? 1 : 0;
      tg = (t == 1) ? mtgt[m][i] : pc + 32'd4;
      if (m == 0) begin
        o_idx = bus0.pred_idx; o_hit = bus0.pred_hit;
        o_tk = bus0.pred_taken; o_tg = bus0.pred_target;
        o_bc = bus0.branch_cnt; o_mc = bus0.mispred_cnt;
      end else begin
        o_idx = bus1.pred_idx; o_hit = bus1.pred_hit;
        o_tk = bus1.pred_taken; o_tg = bus1.pred_target;
        o_bc = bus1.branch_cnt; o_mc = bus1.mispred_cnt;
      end
      check($sformatf("idx%0d@%h", m, pc), 32'(o_idx), i);
      check($sformatf("hit%0d@%h", m, pc), 32'(o_hit), h);
      check($sformatf("tkn%0d@%h", m, pc), 32'(o_tk), t);
      check($sformatf("tgt%0d@%h", m, pc), o_tg, tg);
      check($sformatf("bcnt%0d", m), o_bc, mbr);
      check($sformatf("mcnt%0d", m), o_mc, mmis);
    end
  endtask

  task automatic upd(logic [31:0] pc, bit tk, logic [31:0] tg,
                     bit mis, bit clr = 1'b0);
    int i0, i1;
    i0 = m_idx(0, pc);
    i1 = m_idx(1, pc);
    bus0.update_en = 1'b1; bus1.update_en = 1'b1;
    bus0.update_idx = 4'(i0); bus1.update_idx = 4'(i1);
    bus0.update_pc = pc; bus1.update_pc = pc;
    bus0.update_taken = tk; bus1.update_taken = tk;
    bus0.update_target = tg; bus1.update_target = tg;
    bus0.update_mispredict = mis;
    bus1.update_mispredict = mis;
    clear = clr;
    look(pc);
    step();
    bus0.update_en = 1'b0; bus1.update_en = 1'b0;
    bus0.update_mispredict = 1'b0;
    bus1.update_mispredict = 1'b0;
    clear = 1'b0;
    if (clr) begin
      m_clear();
    end else begin
      m_apply(0, i0, pc, tk, tg);
      m_apply(1, i1, pc, tk, tg);
    end
    mbr++;
    if (mis) mmis++;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_clear();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    m_reset();
    step();
    nRST = 1'b1;
  endtask

  logic [31:0] pool [8];

  initial begin
    pool[0] = 32'h40;  pool[1] = 32'h440;
    pool[2] = 32'h80;  pool[3] = 32'h1C0;
    pool[4] = 32'h3C;  pool[5] = 32'hFFFF_FFFC;
    pool[6] = 32'h840; pool[7] = 32'h7C;

    nRST = 1'b0; clear = 1'b0;
    bus0.lookup_pc = '0; bus1.lookup_pc = '0;
    bus0.update_en = 1'b0; bus1.update_en = 1'b0;
    bus0.update_idx = '0; bus1.update_idx = '0;
    bus0.update_pc = '0; bus1.update_pc = '0;
    bus0.update_taken = 1'b0; bus1.update_taken = 1'b0;
    bus0.update_target = '0; bus1.update_target = '0;
    bus0.update_mispredict = 1'b0;
    bus1.update_mispredict = 1'b0;
    m_reset();
    #2;
    step();
    nRST = 1'b1;

    // reset state
    look(32'h40);
    check("rst_idx", 32'(bus0.pred_idx), 0);
    check("rst_tgt", bus0.pred_target, 32'h44);

    // allocate; same-cycle lookup sees the old entry
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look(32'h40);
    check("alloc_hit", 32'(bus0.pred_hit), 1);
    check("alloc_tgt", bus0.pred_target, 32'h100);

    // saturation low and high
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    check("nt_tgt", bus0.pred_target, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++)
      upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    check("sat_hi_tkn", 32'(bus0.pred_taken), 1);

    // aliasing replaces the entry
    look(32'h440);
    check("alias_miss", 32'(bus0.pred_hit), 0);
    upd(32'h440, 1'b1, 32'h200, 1'b0);
    look(32'h440);
    check("alias_tgt", bus0.pred_target, 32'h200);
    look(32'h40);
    check("alias_old", 32'(bus0.pred_hit), 0);

    // gshare index follows resolved history
    do_clear();
    upd(32'h80, 1'b1, 32'h300, 1'b0);
    upd(32'h80, 1'b1, 32'h300, 1'b0);
    look(32'h40);
    check("gsh_idx3", 32'(bus1.pred_idx), 3);
    upd(32'h80, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    check("gsh_idx6", 32'(bus1.pred_idx), 6);

    // randomized traffic over a small aliasing PC pool
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_clear();
      end else begin
        upd(pool[$urandom_range(0, 7)], 1'($urandom),
            $urandom & 32'hFFFF_FFFC, 1'($urandom),
            $urandom_range(0, 49) == 0);
      end
      look(pool[$urandom_range(0, 7)]);
    end

    // statistics, clear, stray mispredict
    do_reset();
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    upd(32'h80, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h1C0, 1'b1, 32'h500, 1'b1);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    check("stat_b5", bus0.branch_cnt, 5);
    check("stat_m2", bus0.mispred_cnt, 2);
    bus0.update_mispredict = 1'b1;
    bus1.update_mispredict = 1'b1;
    step();
    bus0.update_mispredict = 1'b0;
    bus1.update_mispredict = 1'b0;
    check("stray_mis", bus0.mispred_cnt, 2);
    do_clear();
    look(32'h40);
    look(32'h1C0);
    check("clr_b5", bus1.branch_cnt, 5);
    upd(32'h40, 1'b1, 32'h100, 1'b1, 1'b1);
    look(32'h40);
    check("clrupd_b6", bus0.branch_cnt, 6);
    check("clrupd_miss", 32'(bus0.pred_hit), 0);

    // asynchronous reset in the middle of an update
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    bus0.update_en = 1'b1; bus1.update_en = 1'b1;
    bus0.update_mispredict = 1'b1;
    bus1.update_mispredict = 1'b1;
    #1;
    nRST = 1'b0;
    m_reset();
    look(32'h40);
    check("arst_bcnt", bus0.branch_cnt, 0);
    check("arst_mcnt", bus1.mispred_cnt, 0);
    bus0.update_en = 1'b0; bus1.update_en = 1'b0;
    bus0.update_mispredict = 1'b0;
    bus1.update_mispredict = 1'b0;
    step();
    nRST = 1'b1;
    look(32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
